// File: rtl/sevenseg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_ctrl_pkg
//
// Shared constants for the seven-segment scan controller:
//   - NUM_DIGITS : number of digit positions on the display
//   - SEG_0..SEG_F, SEG_OFF : active-high glyphs, bit order {g,f,e,d,c,b,a}
//   - digit_onehot() : digit index to active-high one-hot anode vector
// ---------------------------------------------------------------------------
package sevenseg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    // Glyphs are active-high here; the top applies board polarity.
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b1111100;
    localparam logic [6:0] SEG_C   = 7'b0111001;
    localparam logic [6:0] SEG_D   = 7'b1011110;
    localparam logic [6:0] SEG_E   = 7'b1111001;
    localparam logic [6:0] SEG_F   = 7'b1110001;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] sel);
        logic [NUM_DIGITS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_ctrl_if
//
// Bundles the host-side load path and the display-side outputs.
//   master : host / testbench (drives load, data, blank_lz)
//   slave  : sevenseg_scan_ctrl (drives update_pending, digit_sel, nibble,
//            an, seg, frame_done)
//
// Handshake: load is a one-cycle strobe with no ready. The controller
// accepts data on every cycle load is high; a second load before the
// next frame boundary simply replaces the pending value. update_pending
// tells the host whether the last loaded value is still waiting.
// ---------------------------------------------------------------------------
interface sevenseg_scan_ctrl_if #(
    parameter int WIDTH = 4
);
    import sevenseg_scan_ctrl_pkg::*;

    logic                        load;
    logic [WIDTH*NUM_DIGITS-1:0] data;
    logic                        blank_lz;
    logic                        update_pending;
    logic [1:0]                  digit_sel;
    logic [WIDTH-1:0]            nibble;
    logic [NUM_DIGITS-1:0]       an;
    logic [6:0]                  seg;
    logic                        frame_done;

    modport master (
        output load, data, blank_lz,
        input  update_pending, digit_sel, nibble, an, seg, frame_done
    );

    modport slave (
        input  load, data, blank_lz,
        output update_pending, digit_sel, nibble, an, seg, frame_done
    );

endinterface

// File: rtl/sevenseg_scan_ctrl_hex_to_sevenseg.sv
// ---------------------------------------------------------------------------
// hex_to_sevenseg
//
// Combinational 4-bit hex to seven-segment decoder, active-high output.
//   hex : nibble value 0..F
//   seg : segments {g,f,e,d,c,b,a}, 1 = lit
// ---------------------------------------------------------------------------
module hex_to_sevenseg
    import sevenseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_ctrl
//
// Time-multiplexed driver for a 4-digit seven-segment display. A prescaler
// defines the digit slot length; each slot drives one digit. Loaded values
// sit in a pending buffer and are committed to the display register only at
// a frame boundary (last slot of digit 3 ending), so a frame never tears.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : sevenseg_scan_ctrl_if.slave
//                in : load, data, blank_lz
//                out: update_pending, digit_sel, nibble, an, seg, frame_done
// ---------------------------------------------------------------------------
module sevenseg_scan_ctrl
    import sevenseg_scan_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DIGITS     = NUM_DIGITS,
    parameter int PRESCALE   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sevenseg_scan_ctrl_if.slave  bus
);

    localparam int              DATA_W   = WIDTH * DIGITS;
    localparam int              CNT_W    = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [1:0]      DIG_LAST = 2'(DIGITS - 1);
    localparam bit              INVERT   = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = INVERT ? '1 : '0;
    localparam logic [6:0]      SEG_IDLE = INVERT ? ~SEG_OFF : SEG_OFF;

    // Scan state
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            dig_q;
    logic                  tick;
    logic                  boundary;
    logic [1:0]            dig_nxt;

    // Buffers
    logic [DATA_W-1:0]     pend_q;
    logic [DATA_W-1:0]     disp_q;
    logic [DATA_W-1:0]     disp_nxt;
    logic                  up_q;
    logic                  fd_q;

    // Output path
    logic                  refresh_q;
    logic [DIGITS-1:0]     zero_from;
    logic                  blank;
    logic [WIDTH-1:0]      nib_nxt;
    logic [6:0]            glyph;
    logic [6:0]            seg_act;
    logic [NUM_DIGITS-1:0] an_act;
    logic [WIDTH-1:0]      nib_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;

    // -----------------------------------------------------------------------
    // Slot timing and next-state of the display register
    // -----------------------------------------------------------------------
    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        boundary = tick && (dig_q == DIG_LAST);

        dig_nxt = dig_q;
        if (tick) begin
            dig_nxt = (dig_q == DIG_LAST) ? 2'd0 : dig_q + 2'd1;
        end

        // A load landing exactly on the boundary bypasses the pending
        // buffer so the new value is shown without a one-frame delay.
        disp_nxt = disp_q;
        if (boundary) begin
            if (bus.load) begin
                disp_nxt = bus.data;
            end else if (up_q) begin
                disp_nxt = pend_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            dig_q <= 2'd0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            dig_q <= dig_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            disp_q <= '0;
            up_q   <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_q <= bus.data;
            end
            disp_q <= disp_nxt;
            if (boundary) begin
                up_q <= 1'b0;
            end else if (bus.load) begin
                up_q <= 1'b1;
            end
            fd_q <= boundary;
        end
    end

    // -----------------------------------------------------------------------
    // Next-slot output computation
    // -----------------------------------------------------------------------
    // zero_from[k] is set when nibbles k..top of the next display are zero.
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (disp_nxt[(DIGITS-1)*WIDTH +: WIDTH] == '0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (disp_nxt[k*WIDTH +: WIDTH] == '0);
        end
    end

    always_comb begin
        nib_nxt = disp_nxt[int'(dig_nxt)*WIDTH +: WIDTH];
        blank   = bus.blank_lz && (dig_nxt != 2'd0) && zero_from[dig_nxt];
        seg_act = blank ? SEG_OFF : glyph;
        an_act  = digit_onehot(dig_nxt);
    end

    hex_to_sevenseg u_hex (
        .hex (nib_nxt[3:0]),
        .seg (glyph)
    );

    // Outputs are only reloaded at slot starts, which keeps them in step
    // with digit_sel and means blank_lz changes wait for the next slot.
    // refresh_q forces one reload right after reset so digit 0 lights
    // immediately instead of after the first full slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= 1'b1;
            nib_q     <= '0;
            an_q      <= AN_IDLE;
            seg_q     <= SEG_IDLE;
        end else begin
            refresh_q <= 1'b0;
            if (tick || refresh_q) begin
                nib_q <= nib_nxt;
                an_q  <= INVERT ? ~an_act  : an_act;
                seg_q <= INVERT ? ~seg_act : seg_act;
            end
        end
    end

    assign bus.update_pending = up_q;
    assign bus.digit_sel      = dig_q;
    assign bus.nibble         = nib_q;
    assign bus.an             = an_q;
    assign bus.seg            = seg_q;
    assign bus.frame_done     = fd_q;

endmodule
